mux_arbiter: RTL

Two-requester round-robin arbiter that shares the 32-bit 2:1 datapath mux (`basemux`) between requester A and requester B. It drives the mux `select` line from a registered grant state machine and accepts data over valid/ready handshakes. It presents the winning beat on a single registered output channel. Grants are held for bursts of up to `MAX_BURST` beats so a streaming requester is not interrupted every cycle.

---
 rtl/mux_arbiter_if.sv | 26 ++
 rtl/mux_arbiter.sv | 123 ++++++++++++
 2 files changed

// File: rtl/mux_arbiter_if.sv
// Handshake bundle between the two requesters, the arbiter and the downstream consumer.
interface mux_arbiter_if #(
    parameter int unsigned WIDTH = 32
);
    logic             a_valid;
    logic [WIDTH-1:0] a_data;
    logic             a_ready;
    logic             b_valid;
    logic [WIDTH-1:0] b_data;
    logic             b_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;
    logic             select;
    logic             busy;

    modport master (
        output a_valid, a_data, b_valid, b_data, out_ready,
        input  a_ready, b_ready, out_valid, out_data, select, busy
    );

    modport slave (
        input  a_valid, a_data, b_valid, b_data, out_ready,
        output a_ready, b_ready, out_valid, out_data, select, busy
    );
endinterface

// File: rtl/mux_arbiter.sv
// Two-requester round-robin burst arbiter driving a 2:1 data mux into one registered output slot.
// Define MUX_ARBITER_FIXED_PRIORITY_EN to give requester A fixed priority.
module mux_arbiter #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned MAX_BURST = 4
) (
    input logic          clk,
    input logic          rst,
    mux_arbiter_if.slave bus
);
    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StGrantA = 2'd1;
    localparam logic [1:0] StGrantB = 2'd2;
    localparam logic [3:0] LastBeat = 4'(MAX_BURST - 1);

    logic [1:0]       state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             last_a_q, last_a_d;
    logic             select_q, select_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;

    logic             slot_free, a_rdy, b_rdy, accept, cur_valid, rel_grant;
    logic [WIDTH-1:0] mux_data;

    always_comb begin
        slot_free = !out_valid_q || bus.out_ready;
        a_rdy     = (state_q == StGrantA) && slot_free;
        b_rdy     = (state_q == StGrantB) && slot_free;
        accept    = (a_rdy && bus.a_valid) || (b_rdy && bus.b_valid);
        mux_data  = select_q ? bus.a_data : bus.b_data;
        cur_valid = (state_q == StGrantA) ? bus.a_valid : bus.b_valid;
        rel_grant = !cur_valid || (accept && (cnt_q == LastBeat));
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        last_a_d = last_a_q;
        select_d = select_q;
        case (state_q)
            StIdle: begin
                // last_a_q low means B went last, so A takes a tie
                if (bus.a_valid && (!bus.b_valid || !last_a_q)) begin
                    state_d = StGrantA;
                end else if (bus.b_valid) begin
                    state_d = StGrantB;
                end
            end
            StGrantA, StGrantB: begin
                if (rel_grant) begin
                    cnt_d = '0;
`ifdef MUX_ARBITER_FIXED_PRIORITY_EN
                    last_a_d = 1'b0;
                    if (bus.a_valid) begin
                        state_d = StGrantA;
                    end else if (bus.b_valid) begin
                        state_d = StGrantB;
                    end else begin
                        state_d = StIdle;
                    end
`else
                    last_a_d = (state_q == StGrantA);
                    if ((state_q == StGrantA) ? bus.b_valid : bus.a_valid) begin
                        state_d = (state_q == StGrantA) ? StGrantB : StGrantA;
                    end else if (cur_valid) begin
                        state_d = state_q;
                    end else begin
                        state_d = StIdle;
                    end
`endif
                end else if (accept) begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
        if (state_d == StGrantA) begin
            select_d = 1'b1;
        end else if (state_d == StGrantB) begin
            select_d = 1'b0;
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = mux_data;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            last_a_q    <= 1'b0;
            select_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_a_q    <= last_a_d;
            select_q    <= select_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign bus.a_ready   = a_rdy;
    assign bus.b_ready   = b_rdy;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.select    = select_q;
    assign bus.busy      = (state_q != StIdle);
endmodule
